// File: rtl/reg_rename_file.sv
// Architectural register file plus ROB rename-tag table; reads are combinational and show pre-update state.
// Optional `COMMIT_BYPASS_EN` forwards a tag-matching commit to the read ports in the same cycle.
module reg_rename_file #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int IDX_W = 5,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush_in,
  input  logic             rename_en,
  input  logic [IDX_W-1:0] rename_rd,
  input  logic [TAG_W-1:0] rename_tag,
  input  logic [IDX_W-1:0] rs1_idx,
  input  logic [IDX_W-1:0] rs2_idx,
  output logic [TAG_W-1:0] rs1_tag,
  output logic [TAG_W-1:0] rs2_tag,
  output logic [XLEN-1:0]  rs1_val,
  output logic [XLEN-1:0]  rs2_val,
  input  logic             commit_en,
  input  logic [IDX_W-1:0] commit_rd,
  input  logic [XLEN-1:0]  commit_val,
  input  logic [TAG_W-1:0] commit_tag,
  output logic [IDX_W:0]   busy_cnt
);

  logic [XLEN-1:0]  val_q [NREG];
  logic [TAG_W-1:0] tag_q [NREG];
  logic [TAG_W-1:0] tag_d [NREG];
  logic [IDX_W:0]   busy_d;

  logic commit_we;
  logic rename_we;

  assign commit_we = commit_en && rdy_in && (commit_rd != '0);
  assign rename_we = rename_en && rdy_in && !flush_in && (rename_rd != '0);

  // Next-state tag table; rename wins over a same-register commit clear, flush wins over both.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      tag_d[i] = tag_q[i];
      if (i != 0 && rdy_in) begin
        if (flush_in) begin
          tag_d[i] = '0;
        end else begin
          if (commit_we && commit_rd == IDX_W'(i) && tag_q[i] == commit_tag)
            tag_d[i] = '0;
          if (rename_we && rename_rd == IDX_W'(i))
            tag_d[i] = rename_tag;
        end
      end
    end
    tag_d[0] = '0;
  end

  // Counting the next table directly keeps busy_cnt exact for every overlap of rename/commit/flush.
  always_comb begin
    busy_d = '0;
    for (int i = 1; i < NREG; i++)
      busy_d = busy_d + (IDX_W+1)'(tag_d[i] != '0);
  end

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < NREG; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
      busy_cnt <= '0;
    end else if (rdy_in) begin
      for (int i = 0; i < NREG; i++)
        tag_q[i] <= tag_d[i];
      if (commit_we)
        val_q[commit_rd] <= commit_val;
      busy_cnt <= busy_d;
    end
  end

  logic [IDX_W-1:0] rd_idx [2];
  logic [TAG_W-1:0] rd_tag [2];
  logic [XLEN-1:0]  rd_val [2];

  assign rd_idx[0] = rs1_idx;
  assign rd_idx[1] = rs2_idx;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_tag[p] = '0;
      rd_val[p] = '0;
      if (rd_idx[p] != '0) begin
        rd_tag[p] = tag_q[rd_idx[p]];
        rd_val[p] = val_q[rd_idx[p]];
`ifdef COMMIT_BYPASS_EN
        if (commit_we && rd_idx[p] == commit_rd && tag_q[rd_idx[p]] == commit_tag) begin
          rd_tag[p] = '0;
          rd_val[p] = commit_val;
        end
`endif
      end
    end
  end

  assign rs1_tag = rd_tag[0];
  assign rs1_val = rd_val[0];
  assign rs2_tag = rd_tag[1];
  assign rs2_val = rd_val[1];

endmodule
